score_tally: RTL

- Consumes the per-arrow `score`/`finish` levels from every dropper instance in the note chart.
- Detects hit and miss events and accumulates score, current combo and max combo.
- Decides game-over once every note has resolved.
- Sits between the dropper bank and the HUD/hex-display logic; runs on `frame_clk`, one update per frame.

---
 rtl/score_tally.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/score_tally.sv
// ---------------------------------------------------------------------------
// score_tally
//
// Per-frame scorekeeper for the note chart. It watches the score/finish
// levels of every dropper, turns their rising edges into hit and miss
// events, and keeps score, combo, max combo and hit/miss totals. It also
// runs the IDLE/PLAY/OVER game flow.
//
// Ports
//   frame_clk  in   frame clock; one update per rising edge
//   Reset      in   synchronous, active-high reset
//   keycode    in   [7:0] USB keycode: 8'h2c starts a game, 8'h01 returns to idle
//   hit_lvl    in   [N_LANES-1:0] dropper score levels (held 1 after a hit)
//   done_lvl   in   [N_LANES-1:0] dropper finish levels (held 1 once resolved)
//   score      out  [13:0] binary score, saturating at SCORE_MAX
//   score_bcd  out  [15:0] 4-digit BCD of score (combinational from the register)
//   combo      out  [9:0]  current consecutive-hit count, saturates at 1023
//   max_combo  out  [9:0]  highest combo this game
//   hits       out  [6:0]  total hits this game
//   misses     out  [6:0]  total misses this game
//   playing    out  high while in PLAY
//   game_over  out  high while in OVER
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 PLAY, 2 OVER)
// ---------------------------------------------------------------------------
module score_tally #(
  parameter int N_LANES          = 64,
  parameter int POINTS           = 10,
  parameter int COMBO_BONUS_STEP = 10,
  parameter int SCORE_MAX        = 9999
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_LANES-1:0] hit_lvl,
  input  logic [N_LANES-1:0] done_lvl,
  output logic [13:0]        score,
  output logic [15:0]        score_bcd,
  output logic [9:0]         combo,
  output logic [9:0]         max_combo,
  output logic [6:0]         hits,
  output logic [6:0]         misses,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         dbg_state
);

  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_IDLE  = 8'h01;
  localparam logic [7:0] LANES8    = 8'(N_LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_LANES-1:0] prev_hit_q, prev_done_q;
  logic [13:0] score_q, score_d;
  logic [9:0]  combo_q, combo_d;
  logic [9:0]  max_combo_q, max_combo_d;
  logic [6:0]  hits_q, hits_d;
  logic [6:0]  misses_q, misses_d;
  logic        playing_q, playing_d;
  logic        game_over_q, game_over_d;

  // ---------------- edge detection ----------------
  logic [N_LANES-1:0] rise_hit, rise_done, miss_vec;
  logic [6:0]         nh, nm;

  assign rise_hit  = hit_lvl & ~prev_hit_q;
  assign rise_done = done_lvl & ~prev_done_q;
  // A done rise only counts as a miss if the lane was never hit: a lane whose
  // hit and done rise together, or whose done follows an earlier hit, is
  // masked by its (held) hit level.
  assign miss_vec  = rise_done & ~hit_lvl;

  always_comb begin
    nh = 7'd0;
    nm = 7'd0;
    for (int i = 0; i < N_LANES; i++) begin
      nh = nh + {6'd0, rise_hit[i]};
      nm = nm + {6'd0, miss_vec[i]};
    end
  end

  // ---------------- per-frame update values ----------------
  logic [31:0] bonus_steps, per_hit, score_add, score_sum;
  logic [13:0] score_upd;
  logic [10:0] combo_sum;
  logic [9:0]  combo_upd, max_combo_upd;
  logic [6:0]  hits_upd, misses_upd;
  logic [7:0]  resolved;
  logic        all_resolved;

  // The bonus uses the combo as it stood before this frame's hits.
  assign bonus_steps = {22'd0, combo_q} / 32'(COMBO_BONUS_STEP);
  assign per_hit     = 32'(POINTS) + 32'(POINTS) * bonus_steps;
  assign score_add   = {25'd0, nh} * per_hit;
  assign score_sum   = {18'd0, score_q} + score_add;
  assign score_upd   = (score_sum > 32'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];

  assign combo_sum = {1'b0, combo_q} + {4'd0, nh};
  // Any miss in the frame breaks the combo, even if hits landed alongside it.
  assign combo_upd = (nm != 7'd0)          ? 10'd0    :
                     (combo_sum > 11'd1023) ? 10'd1023 : combo_sum[9:0];
  assign max_combo_upd = (combo_upd > max_combo_q) ? combo_upd : max_combo_q;

  assign hits_upd     = hits_q + nh;
  assign misses_upd   = misses_q + nm;
  assign resolved     = {1'b0, hits_upd} + {1'b0, misses_upd};
  assign all_resolved = (resolved >= LANES8);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // In PLAY the frame's events always apply; finishing the chart takes
  // priority over an abort key arriving in the same frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (keycode == KEY_START) state_d = S_PLAY;
      S_PLAY: begin
        if (all_resolved)             state_d = S_OVER;
        else if (keycode == KEY_IDLE) state_d = S_IDLE;
      end
      S_OVER: if (keycode == KEY_IDLE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered from next state) ----------------
  always_comb begin
    playing_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // ---------------- counter datapath ----------------
  always_comb begin
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    if (state_q == S_IDLE && keycode == KEY_START) begin
      score_d     = 14'd0;
      combo_d     = 10'd0;
      max_combo_d = 10'd0;
      hits_d      = 7'd0;
      misses_d    = 7'd0;
    end else if (state_q == S_PLAY) begin
      score_d     = score_upd;
      combo_d     = combo_upd;
      max_combo_d = max_combo_upd;
      hits_d      = hits_upd;
      misses_d    = misses_upd;
    end
  end

  // The previous-level registers track the inputs in every state, so when a
  // game starts they already hold the current levels and stale highs never
  // look like new edges.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prev_hit_q  <= '0;
      prev_done_q <= '0;
      score_q     <= 14'd0;
      combo_q     <= 10'd0;
      max_combo_q <= 10'd0;
      hits_q      <= 7'd0;
      misses_q    <= 7'd0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      prev_hit_q  <= hit_lvl;
      prev_done_q <= done_lvl;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  // ---------------- binary to BCD (shift-and-add-3) ----------------
  // score never exceeds 9999, so four digits always hold a valid result.
  logic [15:0] bcd;
  always_comb begin
    bcd = 16'd0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], score_q[i]};
    end
  end

  assign score     = score_q;
  assign score_bcd = bcd;
  assign combo     = combo_q;
  assign max_combo = max_combo_q;
  assign hits      = hits_q;
  assign misses    = misses_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign dbg_state = state_q;

endmodule
